// File: rtl/pdp8l_tty_pkg.sv
// PDP-8/L tty serial bridge: shared register map, bit positions and TX states.
package pdp8l_tty_pkg;
   localparam logic [1:0] TTREG_KB = 2'd1;
   localparam logic [1:0] TTREG_PR = 2'd2;
   localparam int KBFLAG = 31;
   localparam int PRFLAG = 31;
   localparam int PRFULL = 30;
   localparam int OVS = 16;
   typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_DONE} tx_state_t;
endpackage

// File: rtl/pdp8l_tty_uart_rx.sv
// Serial receiver: synchronizer, start qualification, 8N1 sampling on the shared tick.
module pdp8l_tty_uart_rx
   import pdp8l_tty_pkg::*;
(
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       enable,
   input  logic       tick,
   input  logic       RXD,
   output logic       rxvalid,
   output logic [7:0] rxchar,
   output logic       rxferr_pulse
);
   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;

   rx_state_t  state, state_n;
   logic [1:0] sync;
   logic       rx_prev;
   logic       rx_s;
   logic [3:0] tcnt, tcnt_n;
   logic [2:0] bitn, bitn_n;
   logic [7:0] shreg, shreg_n;

   assign rx_s   = sync[1];
   assign rxchar = shreg;

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         sync    <= 2'b11;
         rx_prev <= 1'b1;
         state   <= R_IDLE;
         tcnt    <= '0;
         bitn    <= '0;
         shreg   <= '0;
      end else begin
         sync    <= {sync[0], RXD};
         rx_prev <= rx_s;
         state   <= state_n;
         tcnt    <= tcnt_n;
         bitn    <= bitn_n;
         shreg   <= shreg_n;
      end
   end

   always_comb begin
      state_n      = state;
      tcnt_n       = tick ? tcnt + 4'd1 : tcnt;
      bitn_n       = bitn;
      shreg_n      = shreg;
      rxvalid      = 1'b0;
      rxferr_pulse = 1'b0;
      case (state)
         R_IDLE: begin
            tcnt_n = '0;
            if (!rx_s && rx_prev) state_n = R_START;
         end
         R_START: begin
            // a start bit that is high again at mid-bit was only a glitch
            if (tick && tcnt == 4'(OVS / 2 - 1)) begin
               tcnt_n  = '0;
               bitn_n  = '0;
               state_n = rx_s ? R_IDLE : R_DATA;
            end
         end
         R_DATA: begin
            if (tick && tcnt == 4'(OVS - 1)) begin
               shreg_n = {rx_s, shreg[7:1]};
               bitn_n  = bitn + 3'd1;
               if (bitn == 3'd7) state_n = R_STOP;
            end
         end
         R_STOP: begin
            if (tick && tcnt == 4'(OVS - 1)) begin
               if (rx_s) begin
                  rxvalid = 1'b1;
                  state_n = R_IDLE;
               end else begin
                  rxferr_pulse = 1'b1;
                  state_n      = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            if (rx_s) state_n = R_IDLE;
         end
         default: state_n = R_IDLE;
      endcase
      if (!enable) begin
         state_n      = R_IDLE;
         rxvalid      = 1'b0;
         rxferr_pulse = 1'b0;
      end
   end
endmodule

// File: rtl/pdp8l_tty_uart.sv
// PDP-8/L tty bridge top: tick generator, TX shifter, RX posting, write arbitration.
module pdp8l_tty_uart
   import pdp8l_tty_pkg::*;
#(
   parameter int CLKDIV   = 651,
   parameter int STOPBITS = 2
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        enable,
   input  logic        iopstart,
   output logic        ttwrite,
   output logic [1:0]  ttwaddr,
   output logic [31:0] ttwdata,
   output logic [1:0]  ttraddr,
   input  logic [31:0] ttrdata,
   input  logic        RXD,
   output logic        TXD,
   output logic        txbusy,
   output logic        rxovr,
   output logic        rxferr,
   input  logic        clrerr
);
   localparam int BITCLK = OVS * CLKDIV;
   localparam int TW = $clog2(BITCLK);
   localparam logic [3:0] LASTBIT = 4'(8 + STOPBITS);

   logic [15:0] tick_cnt;
   logic        tick;
   logic        rxvalid, rxferr_pulse;
   logic [7:0]  rxchar;
   logic        rx_pend;
   logic [7:0]  rx_pchar;
   logic        wr_ok, rx_go, tx_go;
   logic        unused_rd;

   tx_state_t   tx_state, tx_state_n;
   logic [7:0]  tx_sh, tx_sh_n;
   logic [3:0]  tx_bit, tx_bit_n;
   logic [TW-1:0] tx_tmr, tx_tmr_n;
   logic        txd_q, txd_n;

   assign unused_rd = ^ttrdata[29:8];

   always_ff @(posedge CLOCK) begin
      if (RESET)               tick_cnt <= '0;
      else if (tick_cnt == '0) tick_cnt <= 16'(CLKDIV - 1);
      else                     tick_cnt <= tick_cnt - 16'd1;
   end
   assign tick = (tick_cnt == '0);

   pdp8l_tty_uart_rx u_rx (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .enable       (enable),
      .tick         (tick),
      .RXD          (RXD),
      .rxvalid      (rxvalid),
      .rxchar       (rxchar),
      .rxferr_pulse (rxferr_pulse)
   );

   // the tty block drops an IOP that coincides with a write
   assign wr_ok   = enable & ~iopstart;
   assign rx_go   = rx_pend & wr_ok;
   assign tx_go   = (tx_state == TX_DONE) & wr_ok & ~rx_pend;
   assign ttwrite = rx_go | tx_go;
   assign ttraddr = rx_go ? TTREG_KB : TTREG_PR;

   always_comb begin
      ttwaddr = '0;
      ttwdata = '0;
      unique case (1'b1)
         rx_go: begin
            ttwaddr         = TTREG_KB;
            ttwdata[KBFLAG] = 1'b1;
            ttwdata[7:0]    = rx_pchar;
         end
         tx_go: begin
            ttwaddr         = TTREG_PR;
            ttwdata[PRFLAG] = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         rx_pend  <= 1'b0;
         rx_pchar <= '0;
         rxovr    <= 1'b0;
         rxferr   <= 1'b0;
      end else begin
         rx_pend <= rxvalid | (rx_pend & ~rx_go);
         if (rxvalid) rx_pchar <= rxchar;
         if ((rx_go && ttrdata[KBFLAG]) || (rxvalid && rx_pend && !rx_go))
            rxovr <= 1'b1;
         else if (clrerr)
            rxovr <= 1'b0;
         if (rxferr_pulse) rxferr <= 1'b1;
         else if (clrerr)  rxferr <= 1'b0;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         tx_state <= TX_IDLE;
         tx_sh    <= '0;
         tx_bit   <= '0;
         tx_tmr   <= '0;
         txd_q    <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_sh    <= tx_sh_n;
         tx_bit   <= tx_bit_n;
         tx_tmr   <= tx_tmr_n;
         txd_q    <= txd_n;
      end
   end

   always_comb begin
      tx_state_n = tx_state;
      tx_sh_n    = tx_sh;
      tx_bit_n   = tx_bit;
      tx_tmr_n   = tx_tmr;
      txd_n      = txd_q;
      case (tx_state)
         TX_IDLE: begin
            if (enable && ttraddr == TTREG_PR && ttrdata[PRFULL]) begin
               tx_state_n = TX_SHIFT;
               tx_sh_n    = ttrdata[7:0];
               tx_bit_n   = '0;
               tx_tmr_n   = '0;
               txd_n      = 1'b0;
            end
         end
         TX_SHIFT: begin
            if (tx_tmr == TW'(BITCLK - 1)) begin
               tx_tmr_n = '0;
               if (tx_bit == LASTBIT) begin
                  tx_state_n = TX_DONE;
               end else begin
                  // ones shifted in behind the data become the stop bits
                  tx_bit_n = tx_bit + 4'd1;
                  txd_n    = tx_sh[0];
                  tx_sh_n  = {1'b1, tx_sh[7:1]};
               end
            end else begin
               tx_tmr_n = tx_tmr + 1'b1;
            end
         end
         TX_DONE: begin
            if (tx_go) tx_state_n = TX_IDLE;
         end
         default: tx_state_n = TX_IDLE;
      endcase
   end

   assign TXD    = txd_q;
   assign txbusy = (tx_state != TX_IDLE);
endmodule

// File: tb/tb_pdp8l_tty_uart.sv
// Bench for pdp8l_tty_uart: tty register model, serial drivers, write scoreboard.
module tb_pdp8l_tty_uart;
   localparam int CLKDIV = 2;
   localparam int STOPB  = 2;
   localparam int BITN   = 16 * CLKDIV;
   localparam int FRAME  = 1 + 8 + STOPB;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic        enable = 1'b1;
   logic        iopstart = 1'b0;
   logic        ttwrite;
   logic [1:0]  ttwaddr;
   logic [31:0] ttwdata;
   logic [1:0]  ttraddr;
   logic [31:0] ttrdata;
   logic        RXD = 1'b1;
   logic        TXD;
   logic        txbusy;
   logic        rxovr;
   logic        rxferr;
   logic        clrerr = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int kb_stamp = -1;
   int pr_stamp = -1;
   int kb_count = 0;

   logic [31:0] kbq[$];
   logic [31:0] prq[$];

   logic       kbflag = 1'b0, prflag = 1'b0, prfull = 1'b0;
   logic [7:0] kbchar = 8'd0, prchar = 8'd0;
   logic       pr_load_cmd = 1'b0, kb_clr_cmd = 1'b0;
   logic [7:0] pr_cmd_char = 8'd0;

   pdp8l_tty_uart #(.CLKDIV(CLKDIV), .STOPBITS(STOPB)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .enable(enable), .iopstart(iopstart),
      .ttwrite(ttwrite), .ttwaddr(ttwaddr), .ttwdata(ttwdata),
      .ttraddr(ttraddr), .ttrdata(ttrdata), .RXD(RXD), .TXD(TXD),
      .txbusy(txbusy), .rxovr(rxovr), .rxferr(rxferr), .clrerr(clrerr)
   );

   always #5 CLOCK = ~CLOCK;
   always @(posedge CLOCK) cyc <= cyc + 1;

   assign ttrdata = (ttraddr == 2'd1) ? {kbflag, 23'd0, kbchar} :
                    (ttraddr == 2'd2) ? {prflag, prfull, 22'd0, prchar} : 32'd0;

   always @(posedge CLOCK) begin
      if (pr_load_cmd) begin
         prchar <= pr_cmd_char;
         prfull <= 1'b1;
         prflag <= 1'b0;
      end
      if (kb_clr_cmd) kbflag <= 1'b0;
      if (ttwrite && ttwaddr == 2'd1) begin
         kbflag <= ttwdata[31];
         kbchar <= ttwdata[7:0];
      end
      if (ttwrite && ttwaddr == 2'd2) begin
         prflag <= ttwdata[31];
         prfull <= ttwdata[30];
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic fail_msg(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   // monitor: pops the expected write for the addressed register
   always @(negedge CLOCK) begin
      if (!RESET) begin
         if (ttwrite) begin
            chk("wr_during_iop", {31'd0, iopstart}, 32'd0);
            if (ttwaddr == 2'd1) begin
               chk("kb_ttraddr", {30'd0, ttraddr}, 32'd1);
               kb_stamp = cyc;
               kb_count++;
               if (kbq.size() == 0) fail_msg("unexpected_kb_write");
               else chk("kb_wdata", ttwdata, kbq.pop_front());
            end else if (ttwaddr == 2'd2) begin
               pr_stamp = cyc;
               if (prq.size() == 0) fail_msg("unexpected_pr_write");
               else chk("pr_wdata", ttwdata, prq.pop_front());
            end else begin
               chk("bad_waddr", {30'd0, ttwaddr}, 32'd1);
            end
         end else begin
            chk("idle_ttraddr", {30'd0, ttraddr}, 32'd2);
         end
      end
   end

   function automatic logic frame_bit(input logic [7:0] c, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return c[k-1];
      return 1'b1;
   endfunction

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic pr_load(input logic [7:0] c);
      int t;
      t = 0;
      while (txbusy && t < 2000) begin
         step();
         t++;
      end
      if (txbusy) fail_msg("txbusy_timeout");
      pr_cmd_char = c;
      pr_load_cmd = 1'b1;
      prq.push_back(32'h8000_0000);
      step();
      pr_load_cmd = 1'b0;
   endtask

   task automatic check_tx(input logic [7:0] c);
      bit seen;
      seen = 0;
      for (int t = 0; t < 3000 && !seen; t++) begin
         @(negedge CLOCK);
         if (TXD === 1'b0) seen = 1;
      end
      if (!seen) begin
         fail_msg("tx_start_timeout");
         return;
      end
      for (int n = 0; n < FRAME * BITN; n++) begin
         if (n > 0) @(negedge CLOCK);
         if (n % BITN == 1 || n % BITN == BITN / 2 || n % BITN == BITN - 2)
            chk($sformatf("tx_bit%0d_off%0d", n / BITN, n % BITN),
                {31'd0, TXD}, {31'd0, frame_bit(c, n / BITN)});
         if (n == BITN / 2) chk("txbusy_mid", {31'd0, txbusy}, 32'd1);
      end
   endtask

   task automatic send_rx(input logic [7:0] c, input logic stopv, input bit push);
      if (push) kbq.push_back({1'b1, 23'd0, c});
      RXD = 1'b0;
      repeat (BITN) step();
      for (int i = 0; i < 8; i++) begin
         RXD = c[i];
         repeat (BITN) step();
      end
      RXD = stopv;
      repeat (BITN) step();
      RXD = 1'b1;
   endtask

   task automatic pulse_clrerr();
      clrerr = 1'b1;
      step();
      clrerr = 1'b0;
      step();
   endtask

   task automatic kb_clear();
      kb_clr_cmd = 1'b1;
      step();
      kb_clr_cmd = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int rel_cyc, saved;
      logic [7:0] tc, rc;
      int dly;

      repeat (3) @(posedge CLOCK);
      @(negedge CLOCK);
      chk("rst_TXD", {31'd0, TXD}, 32'd1);
      chk("rst_ttwrite", {31'd0, ttwrite}, 32'd0);
      chk("rst_ttwaddr", {30'd0, ttwaddr}, 32'd0);
      chk("rst_ttwdata", ttwdata, 32'd0);
      chk("rst_ttraddr", {30'd0, ttraddr}, 32'd2);
      chk("rst_txbusy", {31'd0, txbusy}, 32'd0);
      chk("rst_rxovr", {31'd0, rxovr}, 32'd0);
      chk("rst_rxferr", {31'd0, rxferr}, 32'd0);
      step();
      RESET = 1'b0;
      repeat (5) step();

      pr_load(8'h41);
      check_tx(8'h41);
      repeat (10) step();

      send_rx(8'h8D, 1'b1, 1);
      repeat (4) step();
      chk("rx8d_rxovr", {31'd0, rxovr}, 32'd0);

      kb_clear();
      send_rx(8'h5A, 1'b1, 1);
      repeat (4) step();
      chk("ovr_first", {31'd0, rxovr}, 32'd0);
      send_rx(8'hC3, 1'b1, 1);
      repeat (4) step();
      chk("ovr_second", {31'd0, rxovr}, 32'd1);
      pulse_clrerr();
      chk("ovr_cleared", {31'd0, rxovr}, 32'd0);

      send_rx(8'h55, 1'b0, 0);
      repeat (4) step();
      chk("ferr_set", {31'd0, rxferr}, 32'd1);
      pulse_clrerr();
      chk("ferr_cleared", {31'd0, rxferr}, 32'd0);
      RXD = 1'b0;
      repeat (4 * CLKDIV) step();
      RXD = 1'b1;
      repeat (20 * BITN) step();
      chk("glitch_ferr", {31'd0, rxferr}, 32'd0);

      iopstart = 1'b1;
      fork
         begin
            pr_load(8'h96);
            check_tx(8'h96);
         end
         send_rx(8'h3C, 1'b1, 1);
      join
      repeat (5) step();
      iopstart = 1'b0;
      rel_cyc = cyc;
      repeat (5) step();
      chk("arb_rx_first", kb_stamp, rel_cyc);
      chk("arb_tx_next", pr_stamp, rel_cyc + 1);

      pr_load(8'hA7);
      repeat (100) step();
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      @(negedge CLOCK);
      chk("rstmid_TXD", {31'd0, TXD}, 32'd1);
      chk("rstmid_txbusy", {31'd0, txbusy}, 32'd0);
      check_tx(8'hA7);
      repeat (10) step();

      saved = kb_count;
      enable = 1'b0;
      send_rx(8'h33, 1'b1, 0);
      repeat (10) step();
      enable = 1'b1;
      repeat (100) step();
      chk("en0_no_write", kb_count, saved);

      for (int it = 0; it < 6; it++) begin
         tc = 8'($urandom_range(0, 255));
         rc = 8'($urandom_range(0, 255));
         dly = $urandom_range(0, 200);
         fork
            begin
               pr_load(tc);
               check_tx(tc);
            end
            begin
               repeat (dly) step();
               send_rx(rc, 1'b1, 1);
            end
            begin
               repeat (30) begin
                  repeat ($urandom_range(5, 30)) step();
                  iopstart = 1'b1;
                  repeat ($urandom_range(1, 3)) step();
                  iopstart = 1'b0;
               end
            end
         join
         repeat (10) step();
      end

      for (int t = 0; t < 2000 && (kbq.size() != 0 || prq.size() != 0); t++) step();
      if (kbq.size() != 0 || prq.size() != 0) fail_msg("writes_missing");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
